// File: rtl/weight_ram_writer.sv
// weight_ram_writer
//   Receives a framed byte stream (SYNC_BYTE, TOTAL_BYTES payload bytes and,
//   optionally, a checksum byte) and writes the payload byte-by-byte into the
//   weight RAM write port. Signals a complete image with done_o and a failed
//   checksum with err_o. Both flags are sticky until the next frame starts.
//
//   Build option: define WEIGHT_WR_CHECKSUM_EN to expect a trailing checksum
//   byte (payload sum mod 256) and enable err_o. Without it, the frame ends
//   after the last payload byte and err_o is tied low.
//
// Ports
//   clk_i       system clock
//   rst_n_i     asynchronous active-low reset
//   s_valid_i   input byte valid
//   s_data_i    input byte
//   s_ready_o   byte accepted this cycle when s_valid_i is high
//   lock_i      downstream is reading RAM, stall acceptance
//   ram_we_o    RAM write enable, one-cycle pulse per payload byte
//   ram_addr_o  RAM write address
//   ram_din_o   RAM write data
//   done_o      complete valid image in RAM (sticky)
//   err_o       last frame failed checksum (sticky)
//
// States
//   IDLE  | waiting for first SYNC_BYTE after reset
//   LOAD  | writing payload bytes to RAM, accumulating checksum
//   CHECK | waiting for the checksum byte (checksum build only)
//   DONE  | image complete; SYNC_BYTE restarts
//   ERR   | checksum mismatch; SYNC_BYTE restarts

module weight_ram_writer #(
  parameter int          TOTAL_BYTES = 715,
  parameter int          ADDR_W      = 10,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  input  logic              lock_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_din_o,
  output logic              done_o,
  output logic              err_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_BYTES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic              done_q, done_d;
`ifdef WEIGHT_WR_CHECKSUM_EN
  logic [7:0]        sum_q, sum_d;
  logic              err_q, err_d;
`endif

  logic accept;
  logic is_sync;

  // Ready is gated by reset so nothing is accepted while the block is held.
  assign s_ready_o = rst_n_i & ~lock_i;
  assign accept    = s_valid_i & s_ready_o;
  assign is_sync   = (s_data_i == SYNC_BYTE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
`ifdef WEIGHT_WR_CHECKSUM_EN
      sum_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
`ifdef WEIGHT_WR_CHECKSUM_EN
      sum_q   <= sum_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = done_q;
`ifdef WEIGHT_WR_CHECKSUM_EN
    sum_d   = sum_q;
    err_d   = err_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        // Only a sync byte starts a frame; everything else is dropped.
        if (accept && is_sync) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
          done_d  = 1'b0;
`ifdef WEIGHT_WR_CHECKSUM_EN
          sum_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        // SYNC_BYTE is plain data here; no restart mid-frame.
        if (accept) begin
          we_d   = 1'b1;
          addr_d = cnt_q;
          din_d  = s_data_i;
`ifdef WEIGHT_WR_CHECKSUM_EN
          sum_d  = sum_q + s_data_i;
`endif
          if (cnt_q == LAST_ADDR) begin
            // cnt stays at the last address; it never wraps.
`ifdef WEIGHT_WR_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

`ifdef WEIGHT_WR_CHECKSUM_EN
      ST_CHECK: begin
        // Checksum byte is compared only, never written to RAM.
        if (accept) begin
          if (s_data_i == sum_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ram_we_o   = we_q;
  assign ram_addr_o = addr_q;
  assign ram_din_o  = din_q;
  assign done_o     = done_q;
`ifdef WEIGHT_WR_CHECKSUM_EN
  assign err_o      = err_q;
`else
  assign err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_weight_ram_writer.sv
module tb_weight_ram_writer;

  localparam int         TOTAL = 715;
  localparam int         AW    = 10;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic          clk;
  logic          rst_n;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          lock;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_din;
  logic          done;
  logic          err;

  weight_ram_writer #(.TOTAL_BYTES(TOTAL), .ADDR_W(AW), .SYNC_BYTE(SYNC)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .s_valid_i  (s_valid),
    .s_data_i   (s_data),
    .s_ready_o  (s_ready),
    .lock_i     (lock),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .done_o     (done),
    .err_o      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for sync, 1 = payload, 2 = checksum byte expected
  int         phase = 0;
  int         idx = 0;
  int         msum = 0;
  logic       exp_we = 0;
  int         exp_addr = 0;
  logic [7:0] exp_din = 0;
  logic       exp_done = 0;
  logic       exp_err = 0;
  logic [7:0] ram_model [0:TOTAL-1];
  logic [7:0] tb_ram    [0:TOTAL-1];
  int         wr_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0; idx = 0; msum = 0;
      exp_we = 0; exp_done = 0; exp_err = 0;
    end else begin
      exp_we = 0;
      if (s_valid && !lock) begin
        if (phase == 1) begin
          exp_we = 1; exp_addr = idx; exp_din = s_data;
          ram_model[idx] = s_data;
          msum = (msum + s_data) % 256;
          idx++;
          if (idx == TOTAL) begin
`ifdef WEIGHT_WR_CHECKSUM_EN
            phase = 2;
`else
            phase = 0; exp_done = 1;
`endif
          end
        end else if (phase == 2) begin
          if (s_data == msum[7:0]) exp_done = 1; else exp_err = 1;
          phase = 0;
        end else if (s_data == SYNC) begin
          phase = 1; idx = 0; msum = 0; exp_done = 0; exp_err = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && ram_we) begin
      if (int'(ram_addr) < TOTAL) tb_ram[ram_addr] <= ram_din;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("ready_in_reset", {31'b0, s_ready}, 0);
      check("we_in_reset", {31'b0, ram_we}, 0);
      check("done_in_reset", {31'b0, done}, 0);
    end else begin
      check("s_ready", {31'b0, s_ready}, {31'b0, !lock});
      check("ram_we", {31'b0, ram_we}, {31'b0, exp_we});
      if (exp_we) begin
        check("ram_addr", 32'(ram_addr), exp_addr);
        check("ram_din", {24'b0, ram_din}, {24'b0, exp_din});
      end
      check("done", {31'b0, done}, {31'b0, exp_done});
      check("err", {31'b0, err}, {31'b0, exp_err});
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] pay [0:TOTAL-1];
  bit         lock_rand = 0;

  always @(posedge clk) begin
    #1;
    if (lock_rand) lock = ($urandom_range(0, 5) == 0);
  end

  function automatic logic [7:0] pay_sum();
    int s = 0;
    for (int i = 0; i < TOTAL; i++) s += pay[i];
    return 8'(s % 256);
  endfunction

  task automatic send(input logic [7:0] b, input int max_gap);
    bit got = 0;
    int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
    repeat (gap) begin
      s_valid = 0;
      @(posedge clk); #1;
    end
    s_valid = 1; s_data = b;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (s_ready) begin got = 1; break; end
    end
    #1;
    s_valid = 0;
    if (!got) check("accept_timeout", 1, 0);
  endtask

  task automatic do_reset();
    s_valid = 0;
    rst_n = 0;
    #1;
    check("rst_s_ready", {31'b0, s_ready}, 0);
    check("rst_ram_we", {31'b0, ram_we}, 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_din", {24'b0, ram_din}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_err", {31'b0, err}, 0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  // lock_at / reset_at < 0 disable the respective event.
  task automatic send_frame(input int gap, input int lock_at, input int reset_at, input bit bad_ck);
    int w0;
    send(SYNC, gap);
    for (int i = 0; i < TOTAL; i++) begin
      if (i == reset_at) begin
        @(posedge clk); #3;
        do_reset();
        return;
      end
      if (i == lock_at) begin
        lock_rand = 0;
        lock = 1; s_valid = 1; s_data = pay[i];
        @(posedge clk); #1;
        w0 = wr_cnt;
        repeat (10) begin @(posedge clk); #1; end
        check("lock_no_write", wr_cnt, w0);
        lock = 0;
      end
      send(pay[i], gap);
    end
`ifdef WEIGHT_WR_CHECKSUM_EN
    send(bad_ck ? pay_sum() + 8'd1 : pay_sum(), gap);
`endif
  endtask

  int w_before;

  initial begin
    rst_n = 0; s_valid = 0; s_data = 0; lock = 0;
    #1;
    check("init_s_ready", {31'b0, s_ready}, 0);
    check("init_done", {31'b0, done}, 0);
    check("init_err", {31'b0, err}, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;

    // Frame of i mod 256, back-to-back.
    for (int i = 0; i < TOTAL; i++) pay[i] = 8'(i % 256);
    check("cksum_pin", {24'b0, pay_sum()}, 32'h17);
    w_before = wr_cnt;
    send_frame(0, -1, -1, 0);
    check("frame1_done", {31'b0, done}, 1);
    check("frame1_err", {31'b0, err}, 0);
    @(posedge clk); #1;
    check("frame1_writes", wr_cnt - w_before, TOTAL);
    check("frame1_ram5", {24'b0, tb_ram[5]}, 5);
    check("frame1_ram714", {24'b0, tb_ram[714]}, 32'hCA);

`ifdef WEIGHT_WR_CHECKSUM_EN
    // Bad checksum, then a good random frame.
    send_frame(0, -1, -1, 1);
    check("bad_err", {31'b0, err}, 1);
    check("bad_done", {31'b0, done}, 0);
    for (int i = 0; i < TOTAL; i++) pay[i] = 8'($urandom);
    send(SYNC, 0);
    check("restart_err_clear", {31'b0, err}, 0);
    for (int i = 0; i < TOTAL; i++) send(pay[i], 1);
    send(pay_sum(), 0);
    check("good_done", {31'b0, done}, 1);
    check("good_err", {31'b0, err}, 0);
`endif

    // Junk in idle, A5 inside payload, random gaps/lock and a long lock.
    w_before = wr_cnt;
    send(8'h00, 0); send(8'h3C, 0); send(8'hFF, 0);
    @(posedge clk); #1;
    check("junk_no_write", wr_cnt, w_before);
    for (int i = 0; i < TOTAL; i++) pay[i] = 8'($urandom);
    pay[5] = SYNC;
    lock_rand = 1;
    send_frame(2, 400, -1, 0);
    lock_rand = 0; lock = 0;
    @(posedge clk); #1;
    check("a5_at_5", {24'b0, tb_ram[5]}, {24'b0, SYNC});
    check("rand_done", {31'b0, done}, 1);
    check("rand_writes", wr_cnt - w_before, TOTAL);

    // Reset after 300 payload bytes, then a complete frame.
    for (int i = 0; i < TOTAL; i++) pay[i] = 8'($urandom);
    send_frame(0, -1, 300, 0);
    check("post_reset_done", {31'b0, done}, 0);
    for (int i = 0; i < TOTAL; i++) pay[i] = 8'($urandom);
    send_frame(1, -1, -1, 0);
    check("after_reset_done", {31'b0, done}, 1);
    check("after_reset_err", {31'b0, err}, 0);
    @(posedge clk); #1;
    begin
      int bad = 0;
      for (int i = 0; i < TOTAL; i++) if (tb_ram[i] !== ram_model[i]) bad++;
      check("ram_image", bad, 0);
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    tests++; fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/weight_ram_writer.md
# weight_ram_writer

Receives a framed byte stream from the host link and writes it byte-by-byte into the on-chip weight RAM. The weight loader can then fetch network parameters (depthwise/pointwise weights, biases, shifts) from RAM instead of a fixed ROM image. Sits between the host byte receiver (UART RX or similar, valid/ready) and the write port of the single-port weight RAM. Signals completion to the loader with `done` and reports frame failures with `err`.

## Interface
- `TOTAL_BYTES`, 715, payload length in bytes; RAM image size.
- `ADDR_W`, 10, RAM address width; requires 2^ADDR_W >= TOTAL_BYTES.
- `SYNC_BYTE`, 8'hA5, frame start marker.

- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `s_valid`  in  1  input byte valid.
- `s_data`  in  8  input byte.
- `s_ready`  out  1  writer accepts `s_data` this cycle.
- `lock`  in  1  downstream is reading RAM; writer must not accept bytes.
- `ram_we`  out  1  RAM write enable, one-cycle pulse per byte.
- `ram_addr`  out  ADDR_W  RAM write address.
- `ram_din`  out  8  RAM write data.
- `done`  out  1  complete, valid image in RAM; sticky.
- `err`  out  1  last frame failed checksum; sticky.

## Operation
- Transfer: a byte is accepted on a rising edge when `s_valid && s_ready`.
- `s_ready` = !`lock` while out of reset; it is 0 during reset.
- FSM states: IDLE, LOAD, CHECK, DONE, ERR. Reset state is IDLE.
- IDLE: accepted byte == SYNC_BYTE -> LOAD, clear `cnt`, `sum`, `done`, `err`. Any other byte is discarded.
- LOAD: each accepted byte is written to RAM at address `cnt`. `sum` <= `sum` + byte (8-bit, mod 256). `cnt` increments. A byte equal to SYNC_BYTE is ordinary data here. When the byte at `cnt` == TOTAL_BYTES-1 is accepted -> CHECK, or -> DONE without checksum (see Configuration).
- CHECK: the next accepted byte is compared with the final `sum`. Equal -> DONE, `done`<=1. Unequal -> ERR, `err`<=1. The checksum byte is not written to RAM.
- DONE / ERR: accepted SYNC_BYTE restarts a frame exactly as from IDLE, clearing `done` and `err`. Other bytes are discarded.
- `cnt` is ADDR_W bits and never exceeds TOTAL_BYTES-1. There is no wrap-around.
- Reset asserted mid-frame: all state and outputs clear immediately. RAM contents are left as written; a partial image is never flagged `done`.
- `lock` mid-frame: stalls acceptance only. State, `cnt` and `sum` hold.

## Timing
- Reset values: `s_ready`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `done`=0, `err`=0.
- Write latency: `ram_we`, `ram_addr` and `ram_din` are registered. They appear the cycle after the accepting edge, valid for exactly one cycle.
- Back-to-back acceptance at one byte per clock is supported: one `ram_we` pulse per cycle, addresses consecutive.
- `done` / `err` rise one cycle after the checksum byte is accepted. With checksum disabled, `done` rises one cycle after the last payload byte is accepted, coincident with its `ram_we` pulse.
- `done` and `err` fall one cycle after a restarting SYNC_BYTE is accepted.
- `s_ready` is combinational from `lock` (plus the reset gate). A `lock` rising on a given cycle blocks acceptance on that same cycle.
- Minimum frame time: 1 + TOTAL_BYTES + 1 accepted bytes (checksum enabled).

## Configuration
- `WEIGHT_WR_CHECKSUM_EN` defined:
  - CHECK state present.
  - Frame is SYNC, payload, then a checksum byte (sum mod 256 of payload).
  - `err` functional.
- Not defined:
  - CHECK omitted; LOAD -> DONE after the last payload byte.
  - `err` tied to 0.
  - Frame is SYNC followed by payload only.

## Test plan
- Reset, `lock`=0, send A5, then 715 bytes of value i mod 256, then checksum 8'h?? (computed by bench) -> 715 `ram_we` pulses at addresses 0..714 with data i mod 256; `done`=1 one cycle after the checksum byte; `err`=0.
- Same frame with checksum+1 -> `err`=1, `done`=0; then a good frame -> `err` clears one cycle after A5, `done`=1 at end.
- Bytes 00, 3C, FF in IDLE, then A5 -> no `ram_we` until the first payload byte; that byte goes to address 0. Payload containing A5 at offset 5 -> written to address 5, no restart.
- `lock`=1 for 10 cycles mid-payload while `s_valid`=1 -> `s_ready`=0, no `ram_we`; resume -> next address continues with no gap or duplicate.
- Assert `rst_n`=0 asynchronously after 300 payload bytes -> all outputs 0 immediately; after release, a full frame completes with `done`=1.
- Build without `WEIGHT_WR_CHECKSUM_EN`: A5 + 715 bytes -> `done`=1 on the cycle of the last `ram_we`; `err` stays 0.
